// File: rtl/ds_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ds_sequencer
//  Expands one data-stack command per handshake into DSOP/ALUOP micro-ops,
//  with a depth precheck and done/err reporting.
//  Optional : DS_SEQUENCER_STATUS_EN adds alu_status input and flags output.
//  Revision : 1.0 - initial release
// ============================================================================
module ds_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 128,
  parameter int SZW   = 8
) (
  input  logic             clk,
  input  logic             async_reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [2:0]       cmd_alu,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] sr0_in,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [SZW-1:0]   ds_size,
  input  logic             stack_overflow,
`ifdef DS_SEQUENCER_STATUS_EN
  input  logic [3:0]       alu_status,
  output logic [3:0]       flags,
`endif
  output logic [3:0]       DSOP,
  output logic [2:0]       ALUOP,
  output logic [WIDTH-1:0] ds_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam logic [2:0] c_OP_NOP  = 3'd0;
  localparam logic [2:0] c_OP_PUSH = 3'd1;
  localparam logic [2:0] c_OP_POP  = 3'd2;
  localparam logic [2:0] c_OP_ALU2 = 3'd3;
  localparam logic [2:0] c_OP_ALU1 = 3'd4;
  localparam logic [2:0] c_OP_DUP  = 3'd5;

  localparam logic [3:0] c_DS_PUSH  = 4'b0110;
  localparam logic [3:0] c_DS_POP   = 4'b1000;
  localparam logic [3:0] c_DS_WRITE = 4'b0010;
  localparam logic [3:0] c_DS_READ  = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXEC    = 3'd1,
    S_ALU     = 3'd2,
    S_POP     = 3'd3,
    S_WB      = 3'd4,
    S_DUPPUSH = 3'd5
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_op, w_op_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic [3:0]       r_dsop, w_dsop_nxt;
  logic [2:0]       r_aluop, w_aluop_nxt;
  logic [WIDTH-1:0] r_ds_data, w_ds_data_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;
  logic [1:0]       r_err_code, w_err_code_nxt;
  logic             r_ready, w_ready_nxt;
  logic [1:0]       w_fail_code;
  logic             w_finish;
  logic             w_ge1, w_ge2, w_full;

  assign w_ge1  = (ds_size != '0);
  assign w_ge2  = (ds_size > SZW'(1));
  assign w_full = (32'(ds_size) >= 32'(DEPTH));

  always_comb begin
    w_fail_code = 2'd0;
    case (cmd_op)
      c_OP_NOP:            w_fail_code = 2'd0;
      c_OP_POP, c_OP_ALU1: if (!w_ge1) w_fail_code = 2'd1;
      c_OP_ALU2:           if (!w_ge2) w_fail_code = 2'd1;
      c_OP_PUSH:           if (w_full || stack_overflow) w_fail_code = 2'd2;
      c_OP_DUP: begin
        if (!w_ge1)                        w_fail_code = 2'd1;
        else if (w_full || stack_overflow) w_fail_code = 2'd2;
      end
      default:             w_fail_code = 2'd3;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_op_nxt       = r_op;
    w_result_nxt   = r_result;
    w_ovf_nxt      = r_ovf;
    w_dsop_nxt     = 4'b0000;
    w_aluop_nxt    = r_aluop;
    w_ds_data_nxt  = r_ds_data;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;
    w_err_code_nxt = r_err_code;
    w_finish       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_ready) begin
          w_busy_nxt  = 1'b1;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = S_EXEC;
          w_op_nxt    = cmd_op;
          if (w_fail_code != 2'd0) begin
            // A rejected command parks as NOP so EXEC simply returns to IDLE
            w_err_nxt      = 1'b1;
            w_err_code_nxt = w_fail_code;
            w_op_nxt       = c_OP_NOP;
          end else begin
            case (cmd_op)
              c_OP_PUSH: begin
                w_dsop_nxt    = c_DS_PUSH;
                w_ds_data_nxt = cmd_data;
                w_done_nxt    = 1'b1;
              end
              c_OP_POP: begin
                w_dsop_nxt = c_DS_POP;
                w_done_nxt = 1'b1;
              end
              c_OP_ALU2, c_OP_ALU1: begin
                w_state_nxt = S_ALU;
                w_dsop_nxt  = c_DS_READ;
                w_aluop_nxt = cmd_alu;
              end
              c_OP_DUP:  w_dsop_nxt = c_DS_READ;
              default:   w_done_nxt = 1'b1;
            endcase
          end
        end
      end
      S_EXEC: begin
        w_ovf_nxt = r_ovf | stack_overflow;
        if (r_op == c_OP_DUP) begin
          w_state_nxt   = S_DUPPUSH;
          w_dsop_nxt    = c_DS_PUSH;
          w_ds_data_nxt = sr0_in;
          w_finish      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end
      S_ALU: begin
        w_ovf_nxt    = r_ovf | stack_overflow;
        w_result_nxt = alu_out;
        if (r_op == c_OP_ALU2) begin
          w_state_nxt = S_POP;
          w_dsop_nxt  = c_DS_POP;
        end else begin
          w_state_nxt   = S_WB;
          w_dsop_nxt    = c_DS_WRITE;
          w_ds_data_nxt = alu_out;
          w_finish      = 1'b1;
        end
      end
      S_POP: begin
        w_ovf_nxt     = r_ovf | stack_overflow;
        w_state_nxt   = S_WB;
        w_dsop_nxt    = c_DS_WRITE;
        w_ds_data_nxt = r_result;
        w_finish      = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase

    // An overflow seen during the sequence turns the completion into an error
    if (w_finish) begin
      if (r_ovf || stack_overflow) begin
        w_err_nxt      = 1'b1;
        w_err_code_nxt = 2'd2;
      end else begin
        w_done_nxt = 1'b1;
      end
    end

    w_ready_nxt = (w_state_nxt == S_IDLE) && !w_done_nxt && !w_err_nxt;
  end

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      r_state    <= S_IDLE;
      r_op       <= c_OP_NOP;
      r_result   <= '0;
      r_ovf      <= 1'b0;
      r_dsop     <= 4'b0000;
      r_aluop    <= 3'd0;
      r_ds_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
      r_ready    <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_op       <= w_op_nxt;
      r_result   <= w_result_nxt;
      r_ovf      <= w_ovf_nxt;
      r_dsop     <= w_dsop_nxt;
      r_aluop    <= w_aluop_nxt;
      r_ds_data  <= w_ds_data_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_err_code <= w_err_code_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

`ifdef DS_SEQUENCER_STATUS_EN
  logic [3:0] r_flags;

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset)          r_flags <= 4'd0;
    else if (r_state == S_ALU) r_flags <= alu_status;
  end

  assign flags = r_flags;
`endif

  assign cmd_ready = r_ready;
  assign DSOP      = r_dsop;
  assign ALUOP     = r_aluop;
  assign ds_data   = r_ds_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign err_code  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_ds_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ds_sequencer
//  Randomized self-checking bench for ds_sequencer against a queue-based
//  data-stack / ALU environment and a command-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ds_sequencer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 128;
  localparam int SZW   = 8;

  logic             clk = 1'b0;
  logic             async_reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op, cmd_alu;
  logic [WIDTH-1:0] cmd_data, sr0_in, alu_out;
  logic [SZW-1:0]   ds_size;
  logic             stack_overflow;
  logic [3:0]       DSOP;
  logic [2:0]       ALUOP;
  logic [WIDTH-1:0] ds_data;
  logic             busy, done, err;
  logic [1:0]       err_code;
`ifdef DS_SEQUENCER_STATUS_EN
  logic [3:0]       alu_status;
  logic [3:0]       flags;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int last_code = 0;
  logic [15:0] stk[$];

  ds_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SZW(SZW)) u_dut (
    .clk            (clk),
    .async_reset    (async_reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_alu        (cmd_alu),
    .cmd_data       (cmd_data),
    .sr0_in         (sr0_in),
    .alu_out        (alu_out),
    .ds_size        (ds_size),
    .stack_overflow (stack_overflow),
`ifdef DS_SEQUENCER_STATUS_EN
    .alu_status     (alu_status),
    .flags          (flags),
`endif
    .DSOP           (DSOP),
    .ALUOP          (ALUOP),
    .ds_data        (ds_data),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .err_code       (err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return b - a;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << 1;
      default: return a;
    endcase
  endfunction

  function automatic logic [15:0] nth(input logic [15:0] q[$], input int from_top);
    if (q.size() > from_top) return q[q.size() - 1 - from_top];
    return 16'h0000;
  endfunction

  // Environment: one clock of the data stack reacting to DSOP, then new inputs
  task automatic step();
    @(negedge clk);
    if (DSOP == 4'b0110) stk.push_back(ds_data);
    else if (DSOP == 4'b1000 && stk.size() > 0) void'(stk.pop_back());
    else if (DSOP == 4'b0010 && stk.size() > 0) stk[stk.size() - 1] = ds_data;
    ds_size = (stk.size() > 255) ? 8'hFF : 8'(stk.size());
    sr0_in  = nth(stk, 0);
    alu_out = alu_f(ALUOP, nth(stk, 0), nth(stk, 1));
`ifdef DS_SEQUENCER_STATUS_EN
    alu_status = 4'($urandom_range(0, 15));
`endif
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!cmd_ready && guard < 10) begin
      step();
      guard++;
    end
    if (guard >= 10) check("accept_wait", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [2:0] alu,
                         input logic [15:0] data, input logic ovf);
    logic [15:0] exp_stk[$];
    logic [15:0] a, b, trace_exp, trace_got;
    int sz, code, lat, ev_cyc, n_done, n_err, busy_bad;
`ifdef DS_SEQUENCER_STATUS_EN
    logic [3:0] st_seen = 4'd0;
`endif
    exp_stk = stk;
    sz   = stk.size();
    a    = nth(stk, 0);
    b    = nth(stk, 1);
    code = 0;
    if (op >= 3'd6) code = 3;
    else if (((op == 3'd2 || op == 3'd4 || op == 3'd5) && sz < 1) || (op == 3'd3 && sz < 2))
      code = 1;
    else if ((op == 3'd1 || op == 3'd5) && (sz >= DEPTH || ovf)) code = 2;

    trace_exp = 16'h0000;
    lat = 1;
    if (code == 0) begin
      case (op)
        3'd1: begin exp_stk.push_back(data); trace_exp = 16'h0006; end
        3'd2: begin void'(exp_stk.pop_back()); trace_exp = 16'h0008; end
        3'd3: begin
          void'(exp_stk.pop_back());
          void'(exp_stk.pop_back());
          exp_stk.push_back(alu_f(alu, a, b));
          trace_exp = 16'h0182;
          lat = 3;
        end
        3'd4: begin exp_stk[sz - 1] = alu_f(alu, a, b); trace_exp = 16'h0012; lat = 2; end
        3'd5: begin exp_stk.push_back(a); trace_exp = 16'h0016; lat = 2; end
        default: ;
      endcase
      if (ovf && (op == 3'd3 || op == 3'd4)) code = 2;
    end
    if (code != 0) last_code = code;

    stack_overflow = ovf;
    cmd_op    = op;
    cmd_alu   = alu;
    cmd_data  = data;
    cmd_valid = 1'b1;
    wait_ready();
    step();
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom_range(0, 7));
    cmd_alu   = 3'($urandom_range(0, 7));
    cmd_data  = 16'($urandom);

    trace_got = 16'h0000;
    ev_cyc = 0; n_done = 0; n_err = 0; busy_bad = 0;
    for (int k = 1; k <= lat + 1; k++) begin
      if (k > 1) step();
`ifdef DS_SEQUENCER_STATUS_EN
      if (k == 1) st_seen = alu_status;
`endif
      if (DSOP != 4'b0000) trace_got = {trace_got[11:0], DSOP};
      if (done) n_done++;
      if (err) n_err++;
      if ((done || err) && ev_cyc == 0) ev_cyc = k;
      if (k <= lat && !busy) busy_bad++;
    end
    check("event_cycle", ev_cyc, lat);
    check("done_count", n_done, (code == 0) ? 1 : 0);
    check("err_count", n_err, (code != 0) ? 1 : 0);
    check("err_code", {30'd0, err_code}, last_code);
    check("dsop_trace", {16'd0, trace_got}, {16'd0, trace_exp});
    check("busy_during", busy_bad, 0);
    check("ready_after", {30'd0, cmd_ready, busy}, 32'd2);
    check("stack_size", stk.size(), exp_stk.size());
    check("stack_top", {16'd0, nth(stk, 0)}, {16'd0, nth(exp_stk, 0)});
`ifdef DS_SEQUENCER_STATUS_EN
    if ((op == 3'd3 || op == 3'd4) && code != 1) check("flags", {28'd0, flags}, {28'd0, st_seen});
`endif
    stack_overflow = 1'b0;
  endtask

  task automatic dup_held_test();
    int first, n_acc, sz0;
    logic drop;
    sz0 = stk.size();
    cmd_op = 3'd5; cmd_alu = 3'd0; cmd_data = 16'h0000; cmd_valid = 1'b1;
    wait_ready();
    step();
    check("dup_t1_dsop", {28'd0, DSOP}, 32'h1);
    cmd_op = 3'd0;
    first = 0; n_acc = 0; drop = 1'b0;
    for (int k = 2; k <= 6; k++) begin
      step();
      if (drop) cmd_valid = 1'b0;
      if (k == 2) begin
        check("dup_t2_dsop", {28'd0, DSOP}, 32'h6);
        check("dup_t2_data", {16'd0, ds_data}, 32'hBEEF);
        check("dup_t2_done", {31'd0, done}, 32'd1);
      end
      if (cmd_valid && cmd_ready) begin
        n_acc++;
        if (first == 0) first = k;
        drop = 1'b1;
      end
    end
    check("held_accept_cycle", first, 3);
    check("held_accept_count", n_acc, 1);
    check("dup_size", stk.size(), sz0 + 1);
    check("dup_top", {16'd0, nth(stk, 0)}, 32'hBEEF);
  endtask

  task automatic reset_mid_alu2();
    cmd_op = 3'd3; cmd_alu = 3'd0; cmd_data = 16'h0000; cmd_valid = 1'b1;
    wait_ready();
    step();
    cmd_valid = 1'b0;
    step();
    async_reset = 1'b0;
    #1;
    check("rst_mid_dsop", {28'd0, DSOP}, 32'h0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    step();
    async_reset = 1'b1;
    step();
    check("rst_rel_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rel_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_rel_err_code", {30'd0, err_code}, 32'd0);
    last_code = 0;
  endtask

  initial begin
    async_reset = 1'b0;
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_alu = 3'd0; cmd_data = '0;
    sr0_in = '0; alu_out = '0; ds_size = '0; stack_overflow = 1'b0;
`ifdef DS_SEQUENCER_STATUS_EN
    alu_status = 4'd0;
`endif
    repeat (3) @(negedge clk);
    async_reset = 1'b1;
    step();
    check("rst_dsop", {28'd0, DSOP}, 32'h0);
    check("rst_aluop", {29'd0, ALUOP}, 32'h0);
    check("rst_ds_data", {16'd0, ds_data}, 32'h0);
    check("rst_flags", {28'd0, busy, done, err, cmd_ready}, 32'h1);
    check("rst_err_code", {30'd0, err_code}, 32'h0);

    run_cmd(3'd1, 3'd0, 16'h1234, 1'b0);
    run_cmd(3'd3, 3'd0, 16'h0000, 1'b0);
    run_cmd(3'd2, 3'd0, 16'h0000, 1'b0);
    run_cmd(3'd1, 3'd0, 16'h0003, 1'b0);
    run_cmd(3'd1, 3'd0, 16'h0004, 1'b0);
    run_cmd(3'd3, 3'd0, 16'h0000, 1'b0);
    check("alu2_add_top", {16'd0, nth(stk, 0)}, 32'h0007);
    run_cmd(3'd4, 3'd5, 16'h0000, 1'b0);
    run_cmd(3'd3, 3'd1, 16'h0000, 1'b1);
    run_cmd(3'd1, 3'd0, 16'hBEEF, 1'b0);
    dup_held_test();
    run_cmd(3'd1, 3'd0, 16'h0011, 1'b0);
    reset_mid_alu2();

    while (stk.size() < DEPTH) run_cmd(3'd1, 3'd0, 16'($urandom), 1'b0);
    run_cmd(3'd1, 3'd0, 16'h5555, 1'b0);
    run_cmd(3'd5, 3'd0, 16'h0000, 1'b0);
    run_cmd(3'd7, 3'd0, 16'h0000, 1'b0);
    run_cmd(3'd6, 3'd0, 16'h0000, 1'b0);
    run_cmd(3'd3, 3'd0, 16'h0000, 1'b0);

    for (int i = 0; i < 120; i++) begin
      run_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 16'($urandom),
              ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
